out_pixel_reader: RTL and testbench
===================================

OUT_PIXEL_READER -- requirements
Module: out_pixel_reader

Interface
REQ-001 Parameter WIDTH, 24, address/read-data width of the output pixel memory port.
REQ-002 Parameter AMOUNT, 90000, number of pixels in one output image.
REQ-003 Parameter PIXEL, 8, pixel width in bits.
REQ-004 Parameter BASE, 90302, global address of output pixel 0.
REQ-005 clk  in  1  single clock; all logic on rising edge.
REQ-006 rst_n  in  1  reset, synchronous, active-low.
REQ-007 start  in  1  one-cycle pulse requesting readout of the full image.
REQ-008 mem_addr  out  WIDTH  global address presented to the output pixel memory read port.
REQ-009 mem_rd  in  WIDTH  memory read data; pixel in bits [PIXEL-1:0], upper bits ignored; valid exactly 1 cycle after the mem_addr sample.
REQ-010 px_data  out  PIXEL  streamed pixel.
REQ-011 px_valid  out  1  px_data holds a pixel.
REQ-012 px_ready  in  1  consumer accepts; transfer occurs when px_valid && px_ready.
REQ-013 px_last  out  1  qualifies px_data as pixel index AMOUNT-1.
REQ-014 busy  out  1  readout in progress.
REQ-015 done  out  1  one-cycle pulse after the last transfer.

Function
REQ-016 FSM states IDLE, READ, DRAIN, DONE; IDLE -> READ on start; READ -> DRAIN when all AMOUNT reads have been issued; DRAIN -> DONE on the px_last transfer; DONE -> IDLE unconditionally after one cycle.
REQ-017 In READ, mem_addr = BASE + issue_idx, with issue_idx counting 0..AMOUNT-1 and incrementing only on cycles where a read is issued.
REQ-018 A read is issued only when (FIFO occupancy + reads in flight) < 2, so read data is never dropped.
REQ-019 Read data captured one cycle after issue is pushed into a 2-entry FIFO with its px_last flag (set for issue_idx AMOUNT-1).
REQ-020 px_valid = FIFO not empty; px_data/px_last = FIFO head; a transfer pops the head.
REQ-021 Simultaneous push and pop at occupancy 2 is impossible by REQ-018; at occupancy 1, push+pop leaves occupancy 1.
REQ-022 px_data and px_last hold stable while px_valid && !px_ready.
REQ-023 Minimum latency start -> first px_valid is 3 cycles; with px_ready held high, sustained throughput is 1 pixel/cycle after fill.
REQ-024 Exactly AMOUNT transfers per start; issue_idx never exceeds AMOUNT-1; mem_addr never exceeds BASE+AMOUNT-1.
REQ-025 start is ignored when state is not IDLE.
REQ-026 busy = 1 in READ and DRAIN; 0 in IDLE and DONE.
REQ-027 done = 1 only in DONE.
REQ-028 In IDLE and DONE, mem_addr = BASE.

Reset
REQ-029 rst_n low at a rising edge forces IDLE, issue_idx 0, FIFO empty, in-flight 0; outputs px_valid 0, px_last 0, px_data 0, busy 0, done 0, mem_addr BASE.
REQ-030 Reset mid-readout aborts it; read data returning in the cycle after reset is discarded; no px_valid until a new start.

Structure
REQ-031 Shared package holds the FSM state enum and the default constants (24, 90000, 8, 90302), common with the output pixel memory.
REQ-032 The 2-entry FIFO is one sub-module, pixel_fifo2, parameterised on PIXEL+1 bits.

Verification
REQ-033 AMOUNT=4, memory preloaded 0x11,0x22,0x33,0x44, px_ready=1, start pulse -> px_data 0x11,0x22,0x33,0x44 on 4 consecutive cycles, px_last only on 0x44, done one cycle after, busy low afterwards.
REQ-034 Same, px_ready toggling 1,0,0,1,0,1,1 -> same 4-value order, no loss or duplication, data stable during stalls, mem_addr stays in 90302..90305.
REQ-035 px_ready=0 for 10 cycles after start -> at most 2 reads issued, px_valid high, px_data 0x11 held.
REQ-036 start re-pulsed mid-readout -> ignored; exactly 4 transfers.
REQ-037 rst_n low for 1 cycle after the 2nd transfer -> all outputs reach reset values next cycle, no px_valid for 5 cycles; new start -> full sequence from 0x11.
REQ-038 AMOUNT=90000 default, ready=1 -> 90000 transfers, last mem_addr 180301, done pulses once.

Source files
------------

// File: rtl/out_pixel_reader_pkg.sv
// out_pixel_reader_pkg
// Shared definitions for the output pixel readout path: the readout FSM
// state type and the default geometry constants, common with the output
// pixel memory.
package out_pixel_reader_pkg;

  localparam int DEF_WIDTH  = 24;     // memory address / read-data width
  localparam int DEF_AMOUNT = 90000;  // pixels per output image
  localparam int DEF_PIXEL  = 8;      // pixel width
  localparam int DEF_BASE   = 90302;  // global address of output pixel 0

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_READ,
    ST_DRAIN,
    ST_DONE
  } rd_state_e;

endpackage

// File: rtl/out_pixel_reader_pixel_fifo2.sv
// pixel_fifo2
// Two-entry FIFO holding {px_last, pixel} words between the memory read
// port and the stream output. slot0 is always the head, so the output is a
// plain register with no read mux.
//   clk, rst_n : clock, synchronous active-low reset
//   push, din  : write one word (ignored when full)
//   pop        : drop the head (ignored when empty)
//   dout       : head word
//   count      : occupancy 0..2
module pixel_fifo2 #(
  parameter int W = 9
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic [1:0]   count
);

  logic [W-1:0] slot0, slot1;
  logic         do_push, do_pop;

  assign do_pop  = pop  && (count != 2'd0);
  assign do_push = push && (count != 2'd2);
  assign dout    = slot0;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      slot0 <= '0;
      slot1 <= '0;
      count <= 2'd0;
    end else begin
      case ({do_push, do_pop})
        2'b01: begin
          slot0 <= slot1;
          count <= count - 2'd1;
        end
        2'b10: begin
          if (count == 2'd0) slot0 <= din;
          else               slot1 <= din;
          count <= count + 2'd1;
        end
        2'b11: begin
          // occupancy unchanged; the new word lands behind the survivor
          if (count == 2'd1) slot0 <= din;
          else begin
            slot0 <= slot1;
            slot1 <= din;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/out_pixel_reader.sv
// out_pixel_reader
// Streams one full output image out of the output pixel memory on a
// start pulse. Reads are issued at BASE+idx, the data (valid one cycle
// later) is parked in a 2-entry FIFO, and the FIFO head drives a
// valid/ready pixel stream with a last flag on the final pixel.
//   clk, rst_n        : clock, synchronous active-low reset
//   start             : one-cycle readout request (ignored unless idle)
//   mem_addr, mem_rd  : memory read port (1-cycle read latency)
//   px_data, px_valid, px_ready, px_last : pixel stream
//   busy              : readout in progress (READ/DRAIN)
//   done              : one-cycle pulse after the last transfer
module out_pixel_reader
  import out_pixel_reader_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int AMOUNT = DEF_AMOUNT,
  parameter int PIXEL  = DEF_PIXEL,
  parameter int BASE   = DEF_BASE
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  output logic [WIDTH-1:0] mem_addr,
  input  logic [WIDTH-1:0] mem_rd,
  output logic [PIXEL-1:0] px_data,
  output logic             px_valid,
  input  logic             px_ready,
  output logic             px_last,
  output logic             busy,
  output logic             done
);

  localparam int IW = (AMOUNT > 1) ? $clog2(AMOUNT) : 1;

  rd_state_e     state;
  logic [IW-1:0] issue_idx;
  logic          inflight, inflight_last;
  logic [1:0]    occ, pending;
  logic [PIXEL:0] fifo_dout;
  logic          issue, pop, last_idx;
  logic          unused_mem_hi;

  assign last_idx = (issue_idx == IW'(AMOUNT - 1));
  assign pop      = px_valid && px_ready;

  // Slots that will be taken by the next edge: a head popped this cycle is
  // already free, which is what lets a full-rate stream keep one read in
  // flight behind one buffered pixel.
  assign pending = occ - 2'(pop) + 2'(inflight);
  assign issue   = (state == ST_READ) && (pending < 2'd2);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state         <= ST_IDLE;
      issue_idx     <= '0;
      inflight      <= 1'b0;
      inflight_last <= 1'b0;
    end else begin
      inflight      <= issue;
      inflight_last <= issue && last_idx;
      case (state)
        ST_IDLE: if (start) begin
          state     <= ST_READ;
          issue_idx <= '0;
        end
        ST_READ: if (issue) begin
          // idx parks at AMOUNT-1 so the address never leaves the image
          if (last_idx) state <= ST_DRAIN;
          else          issue_idx <= issue_idx + IW'(1);
        end
        ST_DRAIN: if (pop && px_last) state <= ST_DONE;
        ST_DONE: begin
          state     <= ST_IDLE;
          issue_idx <= '0;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Reset clears inflight, so data returning right after a reset is dropped.
  pixel_fifo2 #(.W(PIXEL + 1)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (inflight),
    .pop   (pop),
    .din   ({inflight_last, mem_rd[PIXEL-1:0]}),
    .dout  (fifo_dout),
    .count (occ)
  );

  assign unused_mem_hi = ^mem_rd[WIDTH-1:PIXEL];

  assign mem_addr = (state == ST_READ) ? (WIDTH'(BASE) + WIDTH'(issue_idx))
                                       : WIDTH'(BASE);
  assign px_valid = (occ != 2'd0);
  assign px_data  = fifo_dout[PIXEL-1:0];
  assign px_last  = px_valid && fifo_dout[PIXEL];
  assign busy     = (state == ST_READ) || (state == ST_DRAIN);
  assign done     = (state == ST_DONE);

endmodule

// File: tb/tb_out_pixel_reader.sv
module tb_out_pixel_reader;

  localparam int BASE = 90302;
  localparam int NA   = 4;
  localparam int NB   = 37;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start_a, rdy_a, valid_a, last_a, busy_a, done_a;
  logic        start_b, rdy_b, valid_b, last_b, busy_b, done_b;
  logic [23:0] addr_a, rd_a, addr_b, rd_b;
  logic [7:0]  data_a, data_b;

  logic [7:0]  img_a [NA];
  logic [7:0]  img_b [NB];

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  out_pixel_reader #(.WIDTH(24), .AMOUNT(NA), .PIXEL(8), .BASE(BASE)) dut_a (
    .clk(clk), .rst_n(rst_n), .start(start_a), .mem_addr(addr_a), .mem_rd(rd_a),
    .px_data(data_a), .px_valid(valid_a), .px_ready(rdy_a), .px_last(last_a),
    .busy(busy_a), .done(done_a)
  );

  out_pixel_reader #(.WIDTH(24), .AMOUNT(NB), .PIXEL(8), .BASE(BASE)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(start_b), .mem_addr(addr_b), .mem_rd(rd_b),
    .px_data(data_b), .px_valid(valid_b), .px_ready(rdy_b), .px_last(last_b),
    .busy(busy_b), .done(done_b)
  );

  // memories: one-cycle read latency, garbage in the upper bits
  always @(posedge clk) begin
    if (int'(addr_a) >= BASE && int'(addr_a) < BASE + NA)
      rd_a <= {16'($urandom), img_a[int'(addr_a) - BASE]};
    else
      rd_a <= 24'($urandom);
    if (int'(addr_b) >= BASE && int'(addr_b) < BASE + NB)
      rd_b <= {16'($urandom), img_b[int'(addr_b) - BASE]};
    else
      rd_b <= 24'($urandom);
  end

  // observers: record accepted transfers and protocol anomalies
  logic [8:0] got_a [$];
  logic [8:0] got_b [$];
  int         xcyc_a [$];
  int  cyc_a = 0, done_cnt_a = 0, done_cyc_a = 0, stall_err_a = 0, addr_err_a = 0;
  int  done_cnt_b = 0, stall_err_b = 0, addr_err_b = 0;
  logic       pstall_a = 1'b0, plast_a = 1'b0, pstall_b = 1'b0, plast_b = 1'b0;
  logic [7:0] pdata_a = 8'h0, pdata_b = 8'h0;

  always @(negedge clk) begin
    cyc_a <= cyc_a + 1;
    if (rst_n && valid_a && rdy_a) begin
      got_a.push_back({last_a, data_a});
      xcyc_a.push_back(cyc_a);
    end
    if (rst_n && pstall_a && (!valid_a || data_a !== pdata_a || last_a !== plast_a))
      stall_err_a <= stall_err_a + 1;
    pstall_a <= rst_n && valid_a && !rdy_a;
    pdata_a  <= data_a;
    plast_a  <= last_a;
    if (int'(addr_a) < BASE || int'(addr_a) > BASE + NA - 1 ||
        (!busy_a && int'(addr_a) != BASE))
      addr_err_a <= addr_err_a + 1;
    if (done_a) begin
      done_cnt_a <= done_cnt_a + 1;
      done_cyc_a <= cyc_a;
    end
  end

  always @(negedge clk) begin
    if (rst_n && valid_b && rdy_b) got_b.push_back({last_b, data_b});
    if (rst_n && pstall_b && (!valid_b || data_b !== pdata_b || last_b !== plast_b))
      stall_err_b <= stall_err_b + 1;
    pstall_b <= rst_n && valid_b && !rdy_b;
    pdata_b  <= data_b;
    plast_b  <= last_b;
    if (int'(addr_b) < BASE || int'(addr_b) > BASE + NB - 1) addr_err_b <= addr_err_b + 1;
    if (done_b) done_cnt_b <= done_cnt_b + 1;
  end

  // Drives one readout of dut_a; mode 0: ready high, 1: ready pattern,
  // 2: ready high with start re-pulsed mid-readout. Returns at the done cycle.
  task automatic run_a(input int mode, input int budget, output int sc, output bit to);
    bit pat [7];
    pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    to = 1'b1;
    sc = cyc_a;
    for (int i = 0; i < budget; i++) begin
      start_a = (i == 0) || (mode == 2 && (i == 2 || i == 4));
      rdy_a   = (mode == 1 && i < 7) ? pat[i] : 1'b1;
      @(posedge clk); #1;
      if (done_a) begin
        to = 1'b0;
        break;
      end
    end
    start_a = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    start_a = 1'b0; rdy_a = 1'b0; start_b = 1'b0; rdy_b = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    total++; if (valid_a !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b want 0", valid_a); end
    total++; if (last_a !== 1'b0) begin bad++; $display("FAIL reset_last: got %b want 0", last_a); end
    total++; if (data_a !== 8'h00) begin bad++; $display("FAIL reset_data: got %h want 00", data_a); end
    total++; if (busy_a !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", busy_a); end
    total++; if (done_a !== 1'b0) begin bad++; $display("FAIL reset_done: got %b want 0", done_a); end
    total++; if (addr_a !== 24'(BASE)) begin bad++; $display("FAIL reset_addr: got %0d want %0d", addr_a, BASE); end
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    int b, d0, sc; bit to;
    b = got_a.size(); d0 = done_cnt_a;
    run_a(0, 40, sc, to);
    total++; if (to) begin bad++; $display("FAIL basic_timeout: got no done want done"); end
    @(posedge clk); #1;
    total++; if (got_a.size() - b !== NA) begin bad++; $display("FAIL basic_count: got %0d want %0d", got_a.size() - b, NA); end
    for (int k = 0; k < NA; k++) if (got_a.size() > b + k) begin
      total++;
      if (got_a[b+k] !== {k == NA - 1, img_a[k]}) begin
        bad++; $display("FAIL basic_px%0d: got %h want %h", k, got_a[b+k], {k == NA - 1, img_a[k]});
      end
    end
    if (got_a.size() >= b + NA) begin
      total++; if (xcyc_a[b] - sc !== 3) begin bad++; $display("FAIL basic_latency: got %0d want 3", xcyc_a[b] - sc); end
      total++; if (xcyc_a[b+NA-1] - xcyc_a[b] !== NA - 1) begin
        bad++; $display("FAIL basic_rate: got %0d want %0d", xcyc_a[b+NA-1] - xcyc_a[b], NA - 1);
      end
      total++; if (done_cyc_a !== xcyc_a[b+NA-1] + 1) begin
        bad++; $display("FAIL basic_done_cycle: got %0d want %0d", done_cyc_a, xcyc_a[b+NA-1] + 1);
      end
    end
    total++; if (done_cnt_a - d0 !== 1) begin bad++; $display("FAIL basic_done_count: got %0d want 1", done_cnt_a - d0); end
    total++; if (busy_a !== 1'b0 || done_a !== 1'b0) begin bad++; $display("FAIL basic_idle_after: got busy=%b done=%b want 0 0", busy_a, done_a); end
  endtask

  task automatic test_stall_pattern();
    int b, se, ae, sc; bit to;
    b = got_a.size(); se = stall_err_a; ae = addr_err_a;
    run_a(1, 60, sc, to);
    total++; if (to) begin bad++; $display("FAIL stall_timeout: got no done want done"); end
    @(posedge clk); #1;
    total++; if (got_a.size() - b !== NA) begin bad++; $display("FAIL stall_count: got %0d want %0d", got_a.size() - b, NA); end
    for (int k = 0; k < NA; k++) if (got_a.size() > b + k) begin
      total++;
      if (got_a[b+k] !== {k == NA - 1, img_a[k]}) begin
        bad++; $display("FAIL stall_px%0d: got %h want %h", k, got_a[b+k], {k == NA - 1, img_a[k]});
      end
    end
    total++; if (stall_err_a !== se) begin bad++; $display("FAIL stall_hold: got %0d unstable cycles want 0", stall_err_a - se); end
    total++; if (addr_err_a !== ae) begin bad++; $display("FAIL stall_addr_range: got %0d bad cycles want 0", addr_err_a - ae); end
  endtask

  task automatic test_hold();
    int b, se; bit to;
    b = got_a.size(); se = stall_err_a;
    rdy_a = 1'b0; start_a = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      start_a = 1'b0;
    end
    total++; if (valid_a !== 1'b1) begin bad++; $display("FAIL hold_valid: got %b want 1", valid_a); end
    total++; if (data_a !== img_a[0]) begin bad++; $display("FAIL hold_data: got %h want %h", data_a, img_a[0]); end
    total++; if (int'(addr_a) - BASE > 2) begin bad++; $display("FAIL hold_reads: got %0d issued want <=2", int'(addr_a) - BASE); end
    rdy_a = 1'b1; to = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (done_a) begin to = 1'b0; break; end
    end
    total++; if (to) begin bad++; $display("FAIL hold_timeout: got no done want done"); end
    total++; if (got_a.size() - b !== NA) begin bad++; $display("FAIL hold_count: got %0d want %0d", got_a.size() - b, NA); end
    for (int k = 0; k < NA; k++) if (got_a.size() > b + k) begin
      total++;
      if (got_a[b+k] !== {k == NA - 1, img_a[k]}) begin
        bad++; $display("FAIL hold_px%0d: got %h want %h", k, got_a[b+k], {k == NA - 1, img_a[k]});
      end
    end
    total++; if (stall_err_a !== se) begin bad++; $display("FAIL hold_stable: got %0d unstable cycles want 0", stall_err_a - se); end
    @(posedge clk); #1;
  endtask

  task automatic test_restart_ignored();
    int b, d0, sc; bit to;
    b = got_a.size(); d0 = done_cnt_a;
    run_a(2, 40, sc, to);
    total++; if (to) begin bad++; $display("FAIL restart_timeout: got no done want done"); end
    repeat (10) @(posedge clk);
    #1;
    total++; if (got_a.size() - b !== NA) begin bad++; $display("FAIL restart_count: got %0d want %0d", got_a.size() - b, NA); end
    total++; if (done_cnt_a - d0 !== 1) begin bad++; $display("FAIL restart_done_count: got %0d want 1", done_cnt_a - d0); end
  endtask

  task automatic test_reset_mid();
    int b, nv, sc; bit to;
    b = got_a.size();
    rdy_a = 1'b1; start_a = 1'b1; to = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      start_a = 1'b0;
      if (got_a.size() >= b + 2) begin to = 1'b0; break; end
    end
    total++; if (to) begin bad++; $display("FAIL rstmid_timeout: got %0d transfers want 2", got_a.size() - b); end
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    total++; if (valid_a !== 1'b0 || last_a !== 1'b0 || data_a !== 8'h00) begin
      bad++; $display("FAIL rstmid_stream: got v=%b l=%b d=%h want 0 0 00", valid_a, last_a, data_a);
    end
    total++; if (busy_a !== 1'b0 || done_a !== 1'b0 || addr_a !== 24'(BASE)) begin
      bad++; $display("FAIL rstmid_ctrl: got busy=%b done=%b addr=%0d want 0 0 %0d", busy_a, done_a, addr_a, BASE);
    end
    nv = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (valid_a) nv++;
    end
    total++; if (nv !== 0) begin bad++; $display("FAIL rstmid_quiet: got %0d valid cycles want 0", nv); end
    @(posedge clk); #1;
    b = got_a.size();
    run_a(0, 40, sc, to);
    total++; if (to) begin bad++; $display("FAIL rstmid_restart_timeout: got no done want done"); end
    total++; if (got_a.size() - b !== NA) begin bad++; $display("FAIL rstmid_count: got %0d want %0d", got_a.size() - b, NA); end
    for (int k = 0; k < NA; k++) if (got_a.size() > b + k) begin
      total++;
      if (got_a[b+k] !== {k == NA - 1, img_a[k]}) begin
        bad++; $display("FAIL rstmid_px%0d: got %h want %h", k, got_a[b+k], {k == NA - 1, img_a[k]});
      end
    end
    @(posedge clk); #1;
  endtask

  // Larger image, random memory contents and random consumer back-pressure;
  // the reference is simply the image in address order, last flag on the end.
  task automatic test_random();
    for (int r = 0; r < 4; r++) begin
      int b, d0, se, ae;
      bit to;
      logic [8:0] exp_q [$];
      for (int k = 0; k < NB; k++) begin
        img_b[k] = 8'($urandom);
        exp_q.push_back({k == NB - 1, img_b[k]});
      end
      b = got_b.size(); d0 = done_cnt_b; se = stall_err_b; ae = addr_err_b;
      start_b = 1'b1; to = 1'b1;
      for (int i = 0; i < 400; i++) begin
        rdy_b = ($urandom_range(0, 3) != 0);
        @(posedge clk); #1;
        start_b = 1'b0;
        if (done_b) begin to = 1'b0; break; end
      end
      rdy_b = 1'b0;
      @(posedge clk); #1;
      total++; if (to) begin bad++; $display("FAIL rand%0d_timeout: got no done want done", r); end
      total++; if (got_b.size() - b !== NB) begin bad++; $display("FAIL rand%0d_count: got %0d want %0d", r, got_b.size() - b, NB); end
      for (int k = 0; k < NB; k++) if (got_b.size() > b + k) begin
        total++;
        if (got_b[b+k] !== exp_q[k]) begin
          bad++; $display("FAIL rand%0d_px%0d: got %h want %h", r, k, got_b[b+k], exp_q[k]);
        end
      end
      total++; if (stall_err_b !== se) begin bad++; $display("FAIL rand%0d_stable: got %0d unstable want 0", r, stall_err_b - se); end
      total++; if (addr_err_b !== ae) begin bad++; $display("FAIL rand%0d_addr: got %0d bad cycles want 0", r, addr_err_b - ae); end
      total++; if (done_cnt_b - d0 !== 1) begin bad++; $display("FAIL rand%0d_done: got %0d want 1", r, done_cnt_b - d0); end
    end
  endtask

  initial begin
    img_a[0] = 8'h11; img_a[1] = 8'h22; img_a[2] = 8'h33; img_a[3] = 8'h44;
    for (int k = 0; k < NB; k++) img_b[k] = 8'h00;
    test_reset();
    test_basic();
    test_stall_pattern();
    test_hold();
    test_restart_ignored();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
